ysyx_23060240_ifu_fetch_fsm: RTL and testbench

//   Parametrised instruction fetch unit with handshakes on both sides.
//   - Fetch side: request/response to an instruction SRAM with variable latency.
//   - Decode side: valid/ready to IDU.
//   - Owns the PC and accepts redirects from EXU/WBU at any time.
//   - Replaces the free-running PC and combinational DPI fetch.

---
 rtl/ysyx_23060240_ifu_fetch_fsm.sv | 151 +++++++++++++++
 tb/tb_ysyx_23060240_ifu_fetch_fsm.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060240_ifu_fetch_fsm.sv
// ============================================================================
// Module      : ysyx_23060240_ifu_fetch_fsm
// Description : Instruction fetch FSM; owns the PC, variable-latency SRAM port,
//               valid/ready handoff to decode. Option macro: IFU_MISALIGN_CHK_EN
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ysyx_23060240_ifu_fetch_fsm #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned       PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_pc,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [INST_W-1:0] mem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] pc,
    output logic              inst_fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q,    pc_d;
    logic [INST_W-1:0] inst_q,  inst_d;
    logic              drop_q,  drop_d;
    logic              fault_q, fault_d;

    logic              w_misalign;
    logic              w_req_hs;

`ifdef IFU_MISALIGN_CHK_EN
    assign w_misalign   = |pc_q[1:0];
    assign mem_req_addr = pc_q;
`else
    // Without the checker the low bits are simply masked off the bus.
    assign w_misalign   = 1'b0;
    assign mem_req_addr = {pc_q[ADDR_W-1:2], 2'b00};
`endif

    assign mem_req_valid = (state_q == REQ) && !w_misalign;
    assign w_req_hs      = mem_req_valid && mem_req_ready;
    assign inst_valid    = (state_q == HOLD);
    assign inst          = inst_q;
    assign pc            = pc_q;
    assign inst_fault    = fault_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            drop_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            drop_q  <= drop_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        drop_d  = drop_q;
        fault_d = fault_q;

        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (jump_en) begin
                    pc_d = jump_pc;
                end
            end

            REQ: begin
                if (jump_en) begin
                    pc_d = jump_pc;
                    // A request already accepted must have its response swallowed.
                    if (w_req_hs) begin
                        drop_d  = 1'b1;
                        state_d = WAIT;
                    end
                end else if (w_misalign) begin
                    inst_d  = '0;
                    fault_d = 1'b1;
                    state_d = HOLD;
                end else if (w_req_hs) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (jump_en) begin
                    pc_d = jump_pc;
                    if (mem_rsp_valid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (mem_rsp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        inst_d  = mem_rsp_data;
                        state_d = HOLD;
                    end
                end
            end

            HOLD: begin
                if (jump_en) begin
                    pc_d    = jump_pc;
                    fault_d = 1'b0;
                    state_d = REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_q + ADDR_W'(PC_STEP);
                    fault_d = 1'b0;
                    state_d = REQ;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060240_ifu_fetch_fsm.sv
// Directed bench for the fetch FSM: each task drives one scenario cycle by cycle
// and compares outputs against hand-computed values one time unit after posedge.
`default_nettype none

module tb_ysyx_23060240_ifu_fetch_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en;
    logic [31:0] jump_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_fault;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ysyx_23060240_ifu_fetch_fsm dut (
        .clk           (clk),
        .rst           (rst),
        .jump_en       (jump_en),
        .jump_pc       (jump_pc),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .pc            (pc),
        .inst_fault    (inst_fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hFFFF_FFFF;
        repeat (2) tick();
        mem_rsp_valid = 1'b0;
        vectors++;
        if ({mem_req_valid, inst_valid, inst_fault} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected %b", {mem_req_valid, inst_valid, inst_fault}, 3'b000);
        end
        vectors++;
        if (pc !== 32'h8000_0000) begin
            miscompares++;
            $display("FAIL reset_pc: got %h expected %h", pc, 32'h8000_0000);
        end
        vectors++;
        if (inst !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_inst: got %h expected %h", inst, 32'h0);
        end
    endtask

    task automatic test_stream();
        logic [31:0] a;
        logic [31:0] d;
        rst           = 1'b1;
        mem_req_ready = 1'b1;
        inst_ready    = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            a = 32'h8000_0000 + 32'(i) * 32'd4;
            d = 32'h0010_0013 + 32'(i) * 32'h0010_0000;
            vectors++;
            if ({mem_req_valid, inst_valid, mem_req_addr} !== {2'b10, a}) begin
                miscompares++;
                $display("FAIL stream_req[%0d]: got v=%b iv=%b addr=%h expected v=1 iv=0 addr=%h", i, mem_req_valid, inst_valid, mem_req_addr, a);
            end
            tick();
            vectors++;
            if ({mem_req_valid, inst_valid} !== 2'b00) begin
                miscompares++;
                $display("FAIL stream_wait[%0d]: got %b expected %b", i, {mem_req_valid, inst_valid}, 2'b00);
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = d;
            tick();
            mem_rsp_valid = 1'b0;
            vectors++;
            if ({mem_req_valid, inst_valid, inst, pc} !== {2'b01, d, a}) begin
                miscompares++;
                $display("FAIL stream_hold[%0d]: got v=%b iv=%b inst=%h pc=%h expected v=0 iv=1 inst=%h pc=%h", i, mem_req_valid, inst_valid, inst, pc, d, a);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        vectors++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h8000_000C}) begin
            miscompares++;
            $display("FAIL stall_req: got v=%b addr=%h expected v=1 addr=8000000c", mem_req_valid, mem_req_addr);
        end
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hABCD_0001;
        inst_ready    = 1'b0;
        tick();
        // Spurious response while holding must be ignored.
        mem_rsp_data  = 32'h5555_5555;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if ({mem_req_valid, inst_valid, inst, pc} !== {2'b01, 32'hABCD_0001, 32'h8000_000C}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got v=%b iv=%b inst=%h pc=%h expected v=0 iv=1 inst=abcd0001 pc=8000000c", i, mem_req_valid, inst_valid, inst, pc);
            end
        end
        mem_rsp_valid = 1'b0;
        inst_ready    = 1'b1;
        tick();
        vectors++;
        if ({mem_req_valid, inst_valid, mem_req_addr} !== {2'b10, 32'h8000_0010}) begin
            miscompares++;
            $display("FAIL stall_release: got v=%b iv=%b addr=%h expected v=1 iv=0 addr=80000010", mem_req_valid, inst_valid, mem_req_addr);
        end
    endtask

    task automatic test_redirect_wait();
        tick();
        jump_en = 1'b1;
        jump_pc = 32'h8000_1000;
        tick();
        jump_en = 1'b0;
        vectors++;
        if ({mem_req_valid, inst_valid, pc} !== {2'b00, 32'h8000_1000}) begin
            miscompares++;
            $display("FAIL rwait_jump: got v=%b iv=%b pc=%h expected v=0 iv=0 pc=80001000", mem_req_valid, inst_valid, pc);
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        mem_rsp_valid = 1'b0;
        vectors++;
        if ({mem_req_valid, inst_valid, mem_req_addr} !== {2'b10, 32'h8000_1000}) begin
            miscompares++;
            $display("FAIL rwait_drop: got v=%b iv=%b addr=%h expected v=1 iv=0 addr=80001000", mem_req_valid, inst_valid, mem_req_addr);
        end
        tick();
        vectors++;
        if (inst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rwait_no_valid: got %b expected %b", inst_valid, 1'b0);
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h00A0_0093;
        tick();
        mem_rsp_valid = 1'b0;
        vectors++;
        if ({inst_valid, inst, pc} !== {1'b1, 32'h00A0_0093, 32'h8000_1000}) begin
            miscompares++;
            $display("FAIL rwait_refetch: got iv=%b inst=%h pc=%h expected iv=1 inst=00a00093 pc=80001000", inst_valid, inst, pc);
        end
    endtask

    task automatic test_redirect_hold();
        inst_ready = 1'b1;
        jump_en    = 1'b1;
        jump_pc    = 32'h8000_2000;
        tick();
        jump_en    = 1'b0;
        vectors++;
        if ({mem_req_valid, inst_valid, mem_req_addr} !== {2'b10, 32'h8000_2000}) begin
            miscompares++;
            $display("FAIL rhold_addr: got v=%b iv=%b addr=%h expected v=1 iv=0 addr=80002000", mem_req_valid, inst_valid, mem_req_addr);
        end
    endtask

    task automatic test_redirect_req();
        mem_req_ready = 1'b0;
        jump_en       = 1'b1;
        jump_pc       = 32'h8000_3000;
        tick();
        jump_en       = 1'b0;
        vectors++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h8000_3000}) begin
            miscompares++;
            $display("FAIL rreq_nohs: got v=%b addr=%h expected v=1 addr=80003000", mem_req_valid, mem_req_addr);
        end
        tick();
        vectors++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h8000_3000}) begin
            miscompares++;
            $display("FAIL rreq_stable: got v=%b addr=%h expected v=1 addr=80003000", mem_req_valid, mem_req_addr);
        end
        mem_req_ready = 1'b1;
        tick();
        jump_en       = 1'b1;
        jump_pc       = 32'h8000_4000;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h1111_1111;
        tick();
        jump_en       = 1'b0;
        mem_rsp_valid = 1'b0;
        vectors++;
        if ({mem_req_valid, inst_valid, mem_req_addr} !== {2'b10, 32'h8000_4000}) begin
            miscompares++;
            $display("FAIL rreq_wait_rsp: got v=%b iv=%b addr=%h expected v=1 iv=0 addr=80004000", mem_req_valid, inst_valid, mem_req_addr);
        end
        jump_en = 1'b1;
        jump_pc = 32'h8000_5000;
        tick();
        jump_en = 1'b0;
        vectors++;
        if ({mem_req_valid, inst_valid, pc} !== {2'b00, 32'h8000_5000}) begin
            miscompares++;
            $display("FAIL rreq_hs_jump: got v=%b iv=%b pc=%h expected v=0 iv=0 pc=80005000", mem_req_valid, inst_valid, pc);
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h2222_0000;
        tick();
        mem_rsp_valid = 1'b0;
        vectors++;
        if ({mem_req_valid, inst_valid, mem_req_addr} !== {2'b10, 32'h8000_5000}) begin
            miscompares++;
            $display("FAIL rreq_hs_drop: got v=%b iv=%b addr=%h expected v=1 iv=0 addr=80005000", mem_req_valid, inst_valid, mem_req_addr);
        end
    endtask

    task automatic test_wrap();
        mem_req_ready = 1'b0;
        jump_en       = 1'b1;
        jump_pc       = 32'hFFFF_FFFC;
        tick();
        jump_en       = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h2222_2222;
        tick();
        mem_rsp_valid = 1'b0;
        vectors++;
        if ({inst_valid, pc} !== {1'b1, 32'hFFFF_FFFC}) begin
            miscompares++;
            $display("FAIL wrap_hold: got iv=%b pc=%h expected iv=1 pc=fffffffc", inst_valid, pc);
        end
        inst_ready = 1'b1;
        tick();
        vectors++;
        if ({mem_req_valid, mem_req_addr, pc} !== {1'b1, 32'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL wrap_addr: got v=%b addr=%h pc=%h expected v=1 addr=00000000 pc=00000000", mem_req_valid, mem_req_addr, pc);
        end
    endtask

    task automatic test_misalign();
        mem_req_ready = 1'b0;
        jump_en       = 1'b1;
        jump_pc       = 32'h8000_0002;
        tick();
        jump_en       = 1'b0;
        vectors++;
        if (pc !== 32'h8000_0002) begin
            miscompares++;
            $display("FAIL mis_pc: got %h expected %h", pc, 32'h8000_0002);
        end
`ifdef IFU_MISALIGN_CHK_EN
        vectors++;
        if ({mem_req_valid, inst_valid, inst_fault} !== 3'b000) begin
            miscompares++;
            $display("FAIL mis_noreq: got %b expected %b", {mem_req_valid, inst_valid, inst_fault}, 3'b000);
        end
        inst_ready = 1'b0;
        tick();
        vectors++;
        if ({mem_req_valid, inst_valid, inst_fault, inst, pc} !== {3'b011, 32'h0, 32'h8000_0002}) begin
            miscompares++;
            $display("FAIL mis_fault: got v=%b iv=%b f=%b inst=%h pc=%h expected v=0 iv=1 f=1 inst=0 pc=80000002", mem_req_valid, inst_valid, inst_fault, inst, pc);
        end
        inst_ready = 1'b1;
        tick();
        vectors++;
        if ({mem_req_valid, inst_valid, inst_fault, pc} !== {3'b000, 32'h8000_0006}) begin
            miscompares++;
            $display("FAIL mis_clear: got v=%b iv=%b f=%b pc=%h expected v=0 iv=0 f=0 pc=80000006", mem_req_valid, inst_valid, inst_fault, pc);
        end
`else
        vectors++;
        if ({mem_req_valid, inst_fault, mem_req_addr} !== {2'b10, 32'h8000_0000}) begin
            miscompares++;
            $display("FAIL mis_addr: got v=%b f=%b addr=%h expected v=1 f=0 addr=80000000", mem_req_valid, inst_fault, mem_req_addr);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h4444_4444;
        tick();
        mem_rsp_valid = 1'b0;
        vectors++;
        if ({inst_valid, inst_fault, pc} !== {2'b10, 32'h8000_0002}) begin
            miscompares++;
            $display("FAIL mis_hold: got iv=%b f=%b pc=%h expected iv=1 f=0 pc=80000002", inst_valid, inst_fault, pc);
        end
        inst_ready = 1'b1;
        tick();
        vectors++;
        if ({mem_req_valid, mem_req_addr, pc} !== {1'b1, 32'h8000_0004, 32'h8000_0006}) begin
            miscompares++;
            $display("FAIL mis_next: got v=%b addr=%h pc=%h expected v=1 addr=80000004 pc=80000006", mem_req_valid, mem_req_addr, pc);
        end
`endif
        mem_req_ready = 1'b0;
        jump_en       = 1'b1;
        jump_pc       = 32'h8000_0100;
        tick();
        jump_en       = 1'b0;
        vectors++;
        if ({mem_req_valid, inst_fault, mem_req_addr} !== {2'b10, 32'h8000_0100}) begin
            miscompares++;
            $display("FAIL mis_realign: got v=%b f=%b addr=%h expected v=1 f=0 addr=80000100", mem_req_valid, inst_fault, mem_req_addr);
        end
    endtask

    task automatic test_reset_mid();
        mem_req_ready = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        vectors++;
        if ({mem_req_valid, inst_valid, pc, inst} !== {2'b00, 32'h8000_0000, 32'h0}) begin
            miscompares++;
            $display("FAIL rmid_abort: got v=%b iv=%b pc=%h inst=%h expected v=0 iv=0 pc=80000000 inst=0", mem_req_valid, inst_valid, pc, inst);
        end
        rst           = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h3333_3333;
        tick();
        vectors++;
        if ({mem_req_valid, inst_valid, mem_req_addr} !== {2'b10, 32'h8000_0000}) begin
            miscompares++;
            $display("FAIL rmid_late_rsp: got v=%b iv=%b addr=%h expected v=1 iv=0 addr=80000000", mem_req_valid, inst_valid, mem_req_addr);
        end
        mem_req_ready = 1'b0;
        tick();
        mem_rsp_valid = 1'b0;
        vectors++;
        if ({mem_req_valid, inst_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL rmid_req_hold: got %b expected %b", {mem_req_valid, inst_valid}, 2'b10);
        end
        rst = 1'b0;
        tick();
        rst     = 1'b1;
        jump_en = 1'b1;
        jump_pc = 32'h8000_0200;
        tick();
        jump_en = 1'b0;
        vectors++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h8000_0200}) begin
            miscompares++;
            $display("FAIL idle_jump: got v=%b addr=%h expected v=1 addr=80000200", mem_req_valid, mem_req_addr);
        end
    endtask

    initial begin
        rst           = 1'b0;
        jump_en       = 1'b0;
        jump_pc       = 32'h0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        inst_ready    = 1'b0;

        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_redirect_req();
        test_wrap();
        test_misalign();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
